pc_gen_btb: RTL
===============

Name: pc_gen_btb

Overview:
- Fetch-stage PC generator for the pipelined MIPS core: holds the fetch PC register and selects the next PC.
- Generalises the combinational branch/jump target logic:
  - parametrised address width;
  - stall/hold;
  - exception redirect;
  - a direct-mapped branch target buffer (BTB) with 2-bit counters for next-cycle prediction.
- Branch/jump resolution arrives from ID. Targets are recomputed internally and compared against the prediction carried down the pipe; a mispredict redirects fetch and raises flush.

Parameters:
- ADDR_W, 32, PC width; legal range 28..32.
- BTB_DEPTH, 16, number of BTB entries; power of 2, minimum 2. IDX_W = log2(BTB_DEPTH).
- RESET_PC, 32'h0000_3000, fetch PC after reset (truncated to ADDR_W).
- EXC_VEC, 32'h0000_4180, exception entry PC (truncated to ADDR_W).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold fetch_pc (hazard unit)
- exc_req  in  1  exception taken; redirect to EXC_VEC
- fetch_pc  out  ADDR_W  current fetch PC (register)
- pred_taken  out  1  BTB predicts fetch_pc is a taken branch/jump
- pred_target  out  ADDR_W  predicted target; 0 when pred_taken=0
- res_valid  in  1  ID-stage resolution valid
- res_is_br  in  1  conditional branch
- res_is_j  in  1  J/JAL (direct jump)
- res_taken  in  1  branch condition outcome; ignored when res_is_j
- res_pc  in  ADDR_W  PC of the resolving instruction
- res_instr  in  32  instruction word; [25:0] = jump index
- res_imm  in  32  sign-extended immediate
- res_pred_taken  in  1  prediction that travelled with the instruction
- res_pred_target  in  ADDR_W  predicted target that travelled with it
- flush  out  1  combinational; kill the IF-stage instruction
- mispredict_cnt  out  16  saturating count of mispredicts

Behaviour:
- Reset (async, rst_n=0):
  - fetch_pc=RESET_PC.
  - All BTB valid bits=0; counters=2'b01; tags/targets=0.
  - mispredict_cnt=0.
  - pred_taken=0, pred_target=0 (follow from the BTB clear).
  - flush follows its inputs (combinational).
  - Reset mid-operation discards every in-flight update.
- Arithmetic (ADDR_W bits, modulo wrap):
  - pc_plus = res_pc + 4.
  - br_tgt = pc_plus + {res_imm[ADDR_W-3:0], 2'b00}.
  - j_tgt = {pc_plus[ADDR_W-1:28], res_instr[25:0], 2'b00}.
  - act_taken = res_is_j | (res_is_br & res_taken).
  - act_tgt = res_is_j ? j_tgt : br_tgt.
- Mispredict:
  - mis = res_valid & (res_is_br|res_is_j) & ((act_taken != res_pred_taken) | (act_taken & act_tgt != res_pred_target)).
  - flush = mis | exc_req.
- Next-PC priority at the clock edge, highest first:
  1. exc_req -> EXC_VEC.
  2. mis -> act_taken ? act_tgt : pc_plus.
  3. stall -> hold fetch_pc.
  4. pred_taken -> pred_target.
  5. otherwise fetch_pc + 4.
  - Redirects override stall.
  - All redirects are visible on fetch_pc exactly one cycle later.
- BTB lookup (combinational from fetch_pc):
  - idx = fetch_pc[IDX_W+1:2]; tag = fetch_pc[ADDR_W-1:IDX_W+2].
  - hit = valid & tag match.
  - pred_taken = hit & ctr[1]; pred_target = entry target when pred_taken, else 0.
- BTB update (registered; on res_valid & (res_is_br|res_is_j); independent of stall and exc_req):
  - Index and tag are taken from res_pc.
  - Hit, branch: ctr saturating +1 if taken, -1 if not; target := br_tgt.
  - Hit, jump: ctr := 2'b11; target := j_tgt.
  - Miss and act_taken: allocate/replace the entry; valid=1, tag, target=act_tgt, ctr = jump ? 2'b11 : 2'b10.
  - Miss and not taken: no change.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents; the update lands at the edge.
- mispredict_cnt increments on each cycle with mis=1 and saturates at 16'hFFFF.
- res_valid=0: no update, mis=0.

Test Plan:
- Reset then release, no stall, no res_valid -> fetch_pc 0x3000, 0x3004, 0x3008 on successive cycles; pred_taken=0 throughout.
- Cold branch: res_pc=0x3000, res_is_br=1, res_taken=1, res_imm=0x0004, res_pred_taken=0 -> flush=1 that cycle, next fetch_pc=0x3014, mispredict_cnt=1. After that, fetch_pc=0x3000 gives pred_taken=1, pred_target=0x3014.
- Jump: res_pc=0x0040_0010, res_instr[25:0]=0x0100000, res_is_j=1, prediction matching -> flush=0, cnt unchanged, BTB ctr=2'b11. With prediction 0 -> next fetch_pc=0x0040_0000.
- Counter decay: branch allocated at ctr 10, two not-taken resolutions -> ctr 01 -> 00. The first not-taken gives flush=1 with next fetch_pc=res_pc+4; lookup then shows pred_taken=0.
- Priority: stall=1 with mis=1 -> redirect wins. exc_req=1 with mis=1 -> fetch_pc=0x4180 and the BTB is still updated. stall alone holds fetch_pc for 3 cycles.
- Async reset asserted mid-run (between edges) -> fetch_pc=0x3000 immediately, BTB cleared (pred_taken=0 on every PC), cnt=0.

Source files
------------

// File: rtl/pc_gen_btb.sv
// Fetch-stage PC generator for the pipelined MIPS core.
// Holds the fetch PC, predicts with a direct-mapped BTB, and redirects on ID mispredicts or exceptions.
module pc_gen_btb #(
  parameter int          ADDR_W    = 32,
  parameter int          BTB_DEPTH = 16,
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC   = 32'h0000_4180
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              exc_req,
  output logic [ADDR_W-1:0] fetch_pc,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              res_valid,
  input  logic              res_is_br,
  input  logic              res_is_j,
  input  logic              res_taken,
  input  logic [ADDR_W-1:0] res_pc,
  input  logic [31:0]       res_instr,
  input  logic [31:0]       res_imm,
  input  logic              res_pred_taken,
  input  logic [ADDR_W-1:0] res_pred_target,
  output logic              flush,
  output logic [15:0]       mispredict_cnt
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [15:0]       cnt_q, cnt_d;

  logic              valid_q [BTB_DEPTH];
  logic [1:0]        ctr_q   [BTB_DEPTH];
  logic [TAG_W-1:0]  tag_q   [BTB_DEPTH];
  logic [ADDR_W-1:0] tgt_q   [BTB_DEPTH];

  logic [IDX_W-1:0]  lk_idx, up_idx;
  logic [TAG_W-1:0]  lk_tag, up_tag;
  logic              lk_hit, up_hit, up_en, up_we;
  logic [1:0]        up_ctr;
  logic [ADDR_W-1:0] up_tgt;

  logic [ADDR_W-1:0] pc_plus, br_tgt, j_tgt, act_tgt;
  logic [31:0]       pc_plus_w, j_tgt_w;
  logic              act_taken, mis;
  logic              unused_bits;

  assign lk_idx      = fetch_pc_q[IDX_W+1:2];
  assign lk_tag      = fetch_pc_q[ADDR_W-1:IDX_W+2];
  assign lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = lk_hit & ctr_q[lk_idx][1];
  assign pred_target = pred_taken ? tgt_q[lk_idx] : '0;
  assign fetch_pc    = fetch_pc_q;

  // Jump target is built at 32 bits so the region bits stay legal for any ADDR_W down to 28.
  assign pc_plus   = res_pc + ADDR_W'(4);
  assign br_tgt    = pc_plus + {res_imm[ADDR_W-3:0], 2'b00};
  assign pc_plus_w = 32'(pc_plus);
  assign j_tgt_w   = {pc_plus_w[31:28], res_instr[25:0], 2'b00};
  assign j_tgt     = j_tgt_w[ADDR_W-1:0];
  assign act_taken = res_is_j | (res_is_br & res_taken);
  assign act_tgt   = res_is_j ? j_tgt : br_tgt;

  assign up_en = res_valid & (res_is_br | res_is_j);
  assign mis   = up_en & ((act_taken != res_pred_taken) |
                          (act_taken & (act_tgt != res_pred_target)));
  assign flush = mis | exc_req;

  assign unused_bits = ^{res_instr[31:26], res_imm[31:ADDR_W-2], pc_plus_w[27:0], j_tgt_w};

  always_comb begin
    fetch_pc_d = fetch_pc_q + ADDR_W'(4);
    if (exc_req)         fetch_pc_d = EXC_VEC[ADDR_W-1:0];
    else if (mis)        fetch_pc_d = act_taken ? act_tgt : pc_plus;
    else if (stall)      fetch_pc_d = fetch_pc_q;
    else if (pred_taken) fetch_pc_d = pred_target;
  end

  assign cnt_d = (mis && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;

  assign up_idx = res_pc[IDX_W+1:2];
  assign up_tag = res_pc[ADDR_W-1:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // Hits train in place; misses only allocate when the instruction actually redirected.
  always_comb begin
    up_we  = 1'b0;
    up_ctr = ctr_q[up_idx];
    up_tgt = tgt_q[up_idx];
    if (up_en) begin
      if (up_hit) begin
        up_we = 1'b1;
        if (res_is_j) begin
          up_ctr = 2'b11;
          up_tgt = j_tgt;
        end else begin
          up_tgt = br_tgt;
          if (res_taken) up_ctr = (ctr_q[up_idx] == 2'b11) ? 2'b11 : ctr_q[up_idx] + 2'd1;
          else           up_ctr = (ctr_q[up_idx] == 2'b00) ? 2'b00 : ctr_q[up_idx] - 2'd1;
        end
      end else if (act_taken) begin
        up_we  = 1'b1;
        up_tgt = act_tgt;
        up_ctr = res_is_j ? 2'b11 : 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC[ADDR_W-1:0];
      cnt_q      <= '0;
      for (int i = 0; i < BTB_DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      cnt_q      <= cnt_d;
      if (up_we) begin
        valid_q[up_idx] <= 1'b1;
        ctr_q[up_idx]   <= up_ctr;
        tag_q[up_idx]   <= up_tag;
        tgt_q[up_idx]   <= up_tgt;
      end
    end
  end

  assign mispredict_cnt = cnt_q;

endmodule
